puf_uart_bridge: RTL

Byte-level command bridge on the host side of the UART's parallel interface. Collects a framed challenge from UART receive bytes, presents it to the PUF core with a valid/ready handshake, captures the PUF response and streams it back as a framed reply through the UART transmit handshake. Sits between the UART and the PUF core in the top level.

---
 rtl/puf_bridge_pkg.sv | 17 +
 rtl/puf_uart_bridge_tx_seq.sv | 52 +++++
 rtl/puf_uart_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/puf_bridge_pkg.sv
// Shared state encoding and default framing bytes for the PUF/UART command bridge.
package puf_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX_CHAL    = 3'd1,
        ISSUE      = 3'd2,
        WAIT_RESP  = 3'd3,
        TX_LOAD    = 3'd4,
        TX_WAIT_LO = 3'd5,
        TX_WAIT_HI = 3'd6
    } state_t;

    localparam logic [7:0] HDR_REQ_DEF = 8'hA5;
    localparam logic [7:0] HDR_RSP_DEF = 8'h5A;

endpackage

// File: rtl/puf_uart_bridge_tx_seq.sv
// One-byte UART send handshake: load on tx_ready, pulse tx_start, then wait for the
// transmitter to go busy and idle again. tx_data is held from tx_start until done.
module puf_tx_seq
    import puf_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       go,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       done,
    output logic [2:0] seq_state
);

    state_t st;

    // done is combinational so the caller can chain the next byte (or go idle) on the same edge.
    assign done      = (st == TX_WAIT_HI) && tx_ready;
    assign seq_state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (st)
                IDLE: begin
                    if (go) st <= TX_LOAD;
                end
                TX_LOAD: begin
                    if (tx_ready) begin
                        tx_data  <= byte_in;
                        tx_start <= 1'b1;
                        st       <= TX_WAIT_LO;
                    end
                end
                TX_WAIT_LO: begin
                    if (!tx_ready) st <= TX_WAIT_HI;
                end
                TX_WAIT_HI: begin
                    if (tx_ready) st <= go ? TX_LOAD : IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/puf_uart_bridge.sv
// Host-side bridge: frames a challenge from UART bytes, hands it to the PUF core,
// and returns the captured response as a header-prefixed reply through the UART.
module puf_uart_bridge
    import puf_bridge_pkg::*;
#(
    parameter int         CHAL_BYTES = 8,
    parameter int         RESP_BYTES = 4,
    parameter int         RX_TIMEOUT = 5000,
    parameter logic [7:0] HDR_REQ    = HDR_REQ_DEF,
    parameter logic [7:0] HDR_RSP    = HDR_RSP_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    input  logic                    rx_err,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_ready,
    output logic [8*CHAL_BYTES-1:0] chal,
    output logic                    chal_valid,
    input  logic                    chal_ready,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    resp_valid,
    output logic                    busy,
    output logic                    frame_err,
    output logic [2:0]              dbg_state
);

    localparam int TW  = $clog2(RX_TIMEOUT) + 1;
    localparam int TXW = 5;

    state_t                  state;
    logic [3:0]              chal_idx;
    logic [TW-1:0]           tmo;
    logic [TXW-1:0]          tx_idx;
    logic [8*RESP_BYTES-1:0] reply;
    logic [7:0]              tx_byte;
    logic                    tx_go;
    logic                    tx_done;
    logic                    tx_last;
    logic [2:0]              seq_state;

    // Reply byte 0 is the header; bytes 1..RESP_BYTES are response bytes, LSB first.
    always_comb begin
        tx_byte = HDR_RSP;
        for (int k = 0; k < RESP_BYTES; k++) begin
            if (tx_idx == TXW'(k + 1)) tx_byte = reply[8*k +: 8];
        end
    end

    assign tx_last = (tx_idx == TXW'(RESP_BYTES));
    assign tx_go   = ((state == WAIT_RESP) && resp_valid) ||
                     ((state == TX_LOAD) && tx_done && !tx_last);

    // While sending, the top sits in TX_LOAD and the sequencer holds the fine-grained state.
    assign dbg_state = (state == TX_LOAD) ? seq_state : state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            chal       <= '0;
            chal_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            reply      <= '0;
            chal_idx   <= '0;
            tmo        <= '0;
            tx_idx     <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_rdy && rx_data == HDR_REQ) begin
                        state    <= RX_CHAL;
                        busy     <= 1'b1;
                        chal_idx <= '0;
                        tmo      <= '0;
                    end
                end
                RX_CHAL: begin
                    if (rx_err) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (rx_rdy) begin
                        for (int k = 0; k < CHAL_BYTES; k++) begin
                            if (chal_idx == 4'(k)) chal[8*k +: 8] <= rx_data;
                        end
                        tmo <= '0;
                        if (chal_idx == 4'(CHAL_BYTES - 1)) begin
                            state      <= ISSUE;
                            chal_valid <= 1'b1;
                        end else begin
                            chal_idx <= chal_idx + 4'd1;
                        end
                    end else if (tmo == TW'(RX_TIMEOUT - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ISSUE: begin
                    if (chal_ready) begin
                        chal_valid <= 1'b0;
                        state      <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (resp_valid) begin
                        reply  <= resp;
                        tx_idx <= '0;
                        state  <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    if (tx_done) begin
                        if (tx_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    puf_tx_seq u_tx_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (tx_byte),
        .go        (tx_go),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .done      (tx_done),
        .seq_state (seq_state)
    );

endmodule
